// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that completes out
// of order (CDB writes) and retires strictly in order from the head.
// Optional feature macro: ROB_CDB_BYPASS_EN -- lets a CDB completion aimed at
// the head entry retire in the same cycle instead of one cycle later.
module reorder_buffer #(
    parameter int ROB_LEN = 8,
    parameter int TAG_W   = $clog2(ROB_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             dispatch_valid,
    input  logic [4:0]       dispatch_dest_idx,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             squash,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic             full,
    output logic [TAG_W-1:0] head_idx,
    output logic             retire,
    output logic [4:0]       retire_dest_idx,
    output logic [31:0]      retire_value,
    output logic [TAG_W:0]   count
);

    // Entry storage. Kept in flops because the async reset has to clear
    // every field immediately.
    logic        valid_reg [ROB_LEN];
    logic        done_reg  [ROB_LEN];
    logic [4:0]  dest_reg  [ROB_LEN];
    logic [31:0] value_reg [ROB_LEN];

    // Queue pointers and occupancy
    logic [TAG_W-1:0] head_reg;
    logic [TAG_W-1:0] head_next;
    logic [TAG_W-1:0] tail_reg;
    logic [TAG_W-1:0] tail_next;
    logic [TAG_W:0]   count_reg;
    logic [TAG_W:0]   count_next;

    // Per-cycle events
    logic        alloc;
    logic        cdb_hit;
    logic        head_valid;
    logic        head_done;
    logic        bypass_hit;
    logic        retire_int;
    logic [31:0] head_value;

    // Full comes only from the registered count, so a same-cycle retire
    // never opens a slot for a dispatch in that cycle.
    assign full = (count_reg == (TAG_W + 1)'(ROB_LEN));

    // Event decode: allocation, valid completion, retire
    always_comb begin
        alloc      = dispatch_valid && !stall && !full && !squash;
        cdb_hit    = cdb_valid && valid_reg[cdb_tag] && !squash;
        head_valid = valid_reg[head_reg];
        head_done  = done_reg[head_reg];
        head_value = value_reg[head_reg];
        bypass_hit = 1'b0;
`ifdef ROB_CDB_BYPASS_EN
        // A completion landing on the waiting head retires straight away
        bypass_hit = cdb_valid && (cdb_tag == head_reg) && head_valid && !head_done;
`else
        bypass_hit = 1'b0;
`endif
        retire_int = head_valid && (head_done || bypass_hit) && !squash;
    end

    // Retire outputs are forced to zero whenever nothing retires
    always_comb begin
        retire          = retire_int;
        retire_dest_idx = 5'd0;
        retire_value    = 32'd0;
        if (retire_int) begin
            retire_dest_idx = dest_reg[head_reg];
            retire_value    = bypass_hit ? cdb_value : head_value;
        end
    end

    assign dispatch_tag = tail_reg;
    assign head_idx     = head_reg;
    assign count        = count_reg;

    // Next-state for pointers and occupancy; both pointers wrap naturally
    // because ROB_LEN is a power of two and TAG_W = log2(ROB_LEN).
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (squash) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (alloc) begin
                tail_next = tail_reg + TAG_W'(1);
            end
            if (retire_int) begin
                head_next = head_reg + TAG_W'(1);
            end
            case ({alloc, retire_int})
                2'b10:   count_next = count_reg + (TAG_W + 1)'(1);
                2'b01:   count_next = count_reg - (TAG_W + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // One register slice per entry. Allocation and retire can never target
    // the same slot (that would need the queue to be both full and non-empty
    // with alloc allowed), so a simple priority chain is enough. Retire wins
    // over a completion so a bypassed entry is left fully cleared.
    for (genvar gi = 0; gi < ROB_LEN; gi++) begin : g_entry
        // Entry gi: squash, allocate, retire or complete
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
                done_reg[gi]  <= 1'b0;
                dest_reg[gi]  <= 5'd0;
                value_reg[gi] <= 32'd0;
            end else if (squash) begin
                valid_reg[gi] <= 1'b0;
                done_reg[gi]  <= 1'b0;
            end else if (alloc && (tail_reg == TAG_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
                done_reg[gi]  <= 1'b0;
                dest_reg[gi]  <= dispatch_dest_idx;
            end else if (retire_int && (head_reg == TAG_W'(gi))) begin
                valid_reg[gi] <= 1'b0;
                done_reg[gi]  <= 1'b0;
            end else if (cdb_hit && (cdb_tag == TAG_W'(gi))) begin
                done_reg[gi]  <= 1'b1;
                value_reg[gi] <= cdb_value;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer (ROB_LEN=8). Expectations follow the
// ROB_CDB_BYPASS_EN setting of the build where the two behaviours differ.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        dispatch_valid;
    logic [4:0]  dispatch_dest_idx;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        squash;
    logic [2:0]  dispatch_tag;
    logic        full;
    logic [2:0]  head_idx;
    logic        retire;
    logic [4:0]  retire_dest_idx;
    logic [31:0] retire_value;
    logic [3:0]  count;

    int n_vec = 0;
    int n_bad = 0;

    reorder_buffer #(.ROB_LEN(8), .TAG_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .dispatch_valid(dispatch_valid),
        .dispatch_dest_idx(dispatch_dest_idx),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_value(cdb_value),
        .squash(squash),
        .dispatch_tag(dispatch_tag),
        .full(full),
        .head_idx(head_idx),
        .retire(retire),
        .retire_dest_idx(retire_dest_idx),
        .retire_value(retire_value),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; dispatch_valid = 1'b0; dispatch_dest_idx = 5'd0;
        cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0; squash = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        $display("step: reset values");
        chk("rst_full", 32'(full), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_head", 32'(head_idx), 0);
        chk("rst_dtag", 32'(dispatch_tag), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdest", 32'(retire_dest_idx), 0);
        chk("rst_rvalue", retire_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three dispatches get tags 0,1,2
        $display("step: dispatch dest 3,5,7");
        dispatch_valid = 1'b1;
        dispatch_dest_idx = 5'd3; #1; chk("d0_tag", 32'(dispatch_tag), 0); tick();
        dispatch_dest_idx = 5'd5; #1; chk("d1_tag", 32'(dispatch_tag), 1); tick();
        dispatch_dest_idx = 5'd7; #1; chk("d2_tag", 32'(dispatch_tag), 2); tick();
        idle(); #1;
        chk("d_count", 32'(count), 3);
        chk("d_retire", 32'(retire), 0);

        // Out-of-order completion, in-order retire
        $display("step: cdb tag1=0xAA then tag0=0x55");
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'hAA; tick();
        cdb_valid = 1'b0; #1;
        chk("c1_retire", 32'(retire), 0);
        chk("c1_head", 32'(head_idx), 0);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'h55; #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("c0_retire", 32'(retire), 1);
        chk("c0_rdest", 32'(retire_dest_idx), 3);
        chk("c0_rvalue", retire_value, 32'h55);
        tick(); idle(); #1;
`else
        chk("c0_retire_early", 32'(retire), 0);
        tick(); idle(); #1;
        chk("c0_retire", 32'(retire), 1);
        chk("c0_rdest", 32'(retire_dest_idx), 3);
        chk("c0_rvalue", retire_value, 32'h55);
        chk("c0_head", 32'(head_idx), 0);
        tick();
`endif
        chk("c1r_retire", 32'(retire), 1);
        chk("c1r_rdest", 32'(retire_dest_idx), 5);
        chk("c1r_rvalue", retire_value, 32'hAA);
        chk("c1r_head", 32'(head_idx), 1);
        tick();
        chk("c2_head", 32'(head_idx), 2);
        chk("c2_retire", 32'(retire), 0);
        chk("c2_count", 32'(count), 1);

        // Asynchronous reset in mid-operation
        $display("step: async reset mid-operation");
        rst_n = 1'b0; #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_head", 32'(head_idx), 0);
        chk("ar_dtag", 32'(dispatch_tag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill all eight entries
        $display("step: fill 8 entries");
        dispatch_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dispatch_dest_idx = 5'(8 + i); #1;
            chk($sformatf("fill%0d_tag", i), 32'(dispatch_tag), 32'(i));
            tick();
        end
        dispatch_dest_idx = 5'd20; #1;
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 8);
        tick();
        chk("rej_count", 32'(count), 8);
        chk("rej_dtag", 32'(dispatch_tag), 0);

        // Dispatch held while full and the head retires: still rejected
        $display("step: retire while full, dispatch held");
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'h99; #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("fr_retire", 32'(retire), 1);
        chk("fr_rvalue", retire_value, 32'h99);
        chk("fr_full", 32'(full), 1);
        tick(); cdb_valid = 1'b0; #1;
`else
        chk("fr_retire_early", 32'(retire), 0);
        tick(); cdb_valid = 1'b0; #1;
        chk("fr_retire", 32'(retire), 1);
        chk("fr_rdest", 32'(retire_dest_idx), 8);
        chk("fr_rvalue", retire_value, 32'h99);
        chk("fr_full", 32'(full), 1);
        chk("fr_count", 32'(count), 8);
        tick();
`endif
        chk("after_ret_count", 32'(count), 7);
        chk("after_ret_full", 32'(full), 0);
        chk("after_ret_head", 32'(head_idx), 1);
        chk("wrap_dtag", 32'(dispatch_tag), 0);
        tick();
        dispatch_valid = 1'b0; #1;
        chk("wrap_count", 32'(count), 8);
        chk("wrap_next_dtag", 32'(dispatch_tag), 1);

        // Complete tags 5..2 (not head), then head tag 1
        $display("step: complete tags 5..1");
        cdb_valid = 1'b1;
        for (int t = 5; t >= 2; t--) begin
            cdb_tag = 3'(t); cdb_value = 32'(32'h100 + t); tick();
        end
        cdb_tag = 3'd1; cdb_value = 32'h101; #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("h1_retire", 32'(retire), 1);
        chk("h1_rvalue", retire_value, 32'h101);
        tick(); cdb_valid = 1'b0; #1;
`else
        tick(); cdb_valid = 1'b0; #1;
        chk("h1_retire", 32'(retire), 1);
        chk("h1_rvalue", retire_value, 32'h101);
        tick();
`endif
        for (int h = 2; h <= 4; h++) begin
            chk($sformatf("r%0d_rdest", h), 32'(retire_dest_idx), 32'(8 + h));
            chk($sformatf("r%0d_rvalue", h), retire_value, 32'(32'h100 + h));
            tick();
        end

        // Dispatch and retire in the same cycle at count 4
        $display("step: dispatch+retire at count 4");
        dispatch_valid = 1'b1; dispatch_dest_idx = 5'd22; #1;
        chk("dr_count", 32'(count), 4);
        chk("dr_retire", 32'(retire), 1);
        chk("dr_rdest", 32'(retire_dest_idx), 13);
        chk("dr_rvalue", retire_value, 32'h105);
        chk("dr_head", 32'(head_idx), 5);
        chk("dr_dtag", 32'(dispatch_tag), 1);
        tick();
        dispatch_valid = 1'b0; #1;
        chk("dr2_count", 32'(count), 4);
        chk("dr2_head", 32'(head_idx), 6);
        chk("dr2_dtag", 32'(dispatch_tag), 2);

        // Squash with 5 entries and a same-cycle CDB to the head
        $display("step: squash with 5 entries");
        dispatch_valid = 1'b1; dispatch_dest_idx = 5'd23; tick();
        chk("sq_pre_count", 32'(count), 5);
        squash = 1'b1; dispatch_dest_idx = 5'd24;
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_value = 32'hEE; #1;
        chk("sq_retire", 32'(retire), 0);
        tick(); idle(); #1;
        chk("sq_count", 32'(count), 0);
        chk("sq_head", 32'(head_idx), 0);
        chk("sq_retire_after", 32'(retire), 0);
        chk("sq_dtag", 32'(dispatch_tag), 0);
        chk("sq_full", 32'(full), 0);

        // CDB to the head: same-cycle retire only with the bypass
        $display("step: cdb to head tag0=0x12");
        dispatch_valid = 1'b1; dispatch_dest_idx = 5'd30; tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'h12; #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("bp_retire", 32'(retire), 1);
        chk("bp_rvalue", retire_value, 32'h12);
        chk("bp_rdest", 32'(retire_dest_idx), 30);
        tick(); cdb_valid = 1'b0; #1;
        chk("bp_retire_after", 32'(retire), 0);
`else
        chk("bp_retire", 32'(retire), 0);
        tick(); cdb_valid = 1'b0; #1;
        chk("bp_retire_after", 32'(retire), 1);
        chk("bp_rvalue", retire_value, 32'h12);
        chk("bp_rdest", 32'(retire_dest_idx), 30);
        tick();
`endif
        chk("bp_count", 32'(count), 0);
        chk("bp_head", 32'(head_idx), 1);

        // Stall blocks allocation but not completion or retire
        $display("step: stall with completion");
        dispatch_valid = 1'b1; dispatch_dest_idx = 5'd31; tick();
        stall = 1'b1; dispatch_dest_idx = 5'd25;
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'h5A; #1;
        chk("st_dtag", 32'(dispatch_tag), 2);
`ifdef ROB_CDB_BYPASS_EN
        chk("st_retire", 32'(retire), 1);
        chk("st_rvalue", retire_value, 32'h5A);
        tick(); cdb_valid = 1'b0; #1;
`else
        tick(); cdb_valid = 1'b0; #1;
        chk("st_count_mid", 32'(count), 1);
        chk("st_retire", 32'(retire), 1);
        chk("st_rdest", 32'(retire_dest_idx), 31);
        chk("st_rvalue", retire_value, 32'h5A);
        tick();
`endif
        chk("st_count", 32'(count), 0);
        chk("st_head", 32'(head_idx), 2);
        chk("st_dtag_end", 32'(dispatch_tag), 2);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_LEN, default 8, giving the number of entries; it SHALL be a power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default $clog2(ROB_LEN), giving the width of the entry index/tag.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  blocks dispatch allocation only.
REQ-006 dispatch_valid  in  1  request to allocate one entry.
REQ-007 dispatch_dest_idx  in  5  architectural destination register of the dispatching instruction.
REQ-008 cdb_valid  in  1  completion broadcast valid.
REQ-009 cdb_tag  in  TAG_W  ROB index of the completing entry.
REQ-010 cdb_value  in  32  result value of the completing entry.
REQ-011 squash  in  1  flushes all entries.
REQ-012 dispatch_tag  out  TAG_W  current tail index; this is the tag given to the dispatching instruction.
REQ-013 full  out  1  high when the entry count equals ROB_LEN.
REQ-014 head_idx  out  TAG_W  current head index, sent to the map table.
REQ-015 retire  out  1  the head entry retires this cycle.
REQ-016 retire_dest_idx  out  5  destination register of the retiring entry.
REQ-017 retire_value  out  32  result value of the retiring entry.
REQ-018 count  out  TAG_W+1  number of occupied entries.

Function
REQ-019 Each entry SHALL hold the fields valid, done, dest_idx[4:0] and value[31:0].
REQ-020 Allocation SHALL occur when dispatch_valid && !stall && !full && !squash.
- Write {valid=1, done=0, dest_idx} into entry[tail].
- tail becomes (tail+1) mod ROB_LEN at the next edge.
REQ-021 dispatch_tag SHALL equal tail combinationally in the same cycle as the request.
REQ-022 full SHALL be decoded from the registered count only.
- A dispatch arriving while full is rejected, even if a retire occurs in the same cycle.
REQ-023 Completion: when cdb_valid is high and entry[cdb_tag].valid is high, the entry SHALL latch done=1 and value=cdb_value at the edge.
- A completion to an invalid entry SHALL be ignored.
REQ-024 retire SHALL be combinational: retire = entry[head].valid && entry[head].done && !squash.
- retire_dest_idx and retire_value SHALL come from entry[head].
- When retire=0, both SHALL be 0.
REQ-025 On retire, the edge SHALL clear entry[head].valid and advance head to (head+1) mod ROB_LEN.
- Exactly one retire is allowed per cycle.
REQ-026 count_next SHALL equal count + alloc - retire.
- Simultaneous alloc and retire leave count unchanged.
- Head and tail SHALL wrap independently.
REQ-027 stall SHALL NOT block completion or retire.
REQ-028 squash SHALL have priority over all other events.
- At the next edge: all valid and done bits are 0, head=tail=0, count=0.
- Dispatch and CDB inputs in that cycle are ignored.
REQ-029 head_idx SHALL always equal the registered head pointer.

Reset
REQ-030 Asserting reset low SHALL immediately, without waiting for a clock edge, clear all of the following:
- head, tail and count to 0;
- all valid, done, dest_idx and value fields to 0.
REQ-031 During reset, outputs SHALL be: full=0, retire=0, head_idx=0, dispatch_tag=0, count=0, retire_dest_idx=0, retire_value=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries; the first allocation after reset release SHALL receive tag 0.

Configuration
REQ-033 Macro ROB_CDB_BYPASS_EN controls a completion-to-retire bypass.
- Defined: when cdb_valid && cdb_tag==head && entry[head].valid && !entry[head].done && !squash, retire SHALL assert in that same cycle, with retire_value=cdb_value.
- Not defined: such an entry retires no earlier than the cycle after the completion edge.

Verification
REQ-034 Reset, then dispatch dest 3, 5, 7 in consecutive cycles -> dispatch_tag is 0, 1, 2; count=3; retire=0.
REQ-035 CDB tag 1 (value 0xAA), then CDB tag 0 (value 0x55) -> retire dest 3 / 0x55, then next cycle dest 5 / 0xAA; head_idx goes 0 -> 1 -> 2.
REQ-036 Fill all 8 entries -> full=1; a 9th dispatch is rejected, with tail and count unchanged; after one retire, the next dispatch gets tag 0 (wrap-around).
REQ-037 count=4, with a dispatch and a retire in the same cycle -> count stays 4; head and tail each advance by 1.
REQ-038 Squash with 5 valid entries, plus a same-cycle CDB to the head -> next cycle count=0, head_idx=0, retire=0, and the next dispatch_tag=0.
REQ-039 With ROB_CDB_BYPASS_EN defined: CDB to head tag 0 with value 0x12 -> retire=1 and retire_value=0x12 in the same cycle; with the macro undefined, retire asserts one cycle later.
